instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: address fetched first after reset.
REQ-002 SHALL have parameter RD_CYCLES, default 2: clock cycles allowed for instruction memory read settle, range 1..15.
REQ-003 SHALL have parameter MEM_SIZE, default 52: first byte address beyond the program; fetch at or beyond it halts.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port address, output, 32: byte address driven to instruction memory.
REQ-007 SHALL have port instr_in, input, 32: instruction word returned by instruction memory.
REQ-008 SHALL have port instr, output, 32: captured instruction to decode.
REQ-009 SHALL have port pc, output, 32: byte address of instr.
REQ-010 SHALL have port instr_valid, output, 1: instr/pc hold a valid fetched word.
REQ-011 SHALL have port instr_ready, input, 1: decode accepts instr this cycle.
REQ-012 SHALL have port redirect_valid, input, 1: branch taken, one-cycle pulse.
REQ-013 SHALL have port redirect_addr, input, 32: branch target byte address.
REQ-014 SHALL have port halted, output, 1: fetch stopped at end of program.
REQ-015 SHALL have port err, output, 1: misaligned redirect detected (see Configuration).

Function
REQ-016 SHALL implement states ISSUE, WAIT, HOLD, HALT.
REQ-017 ISSUE: SHALL drive address = fetch PC, load wait counter with RD_CYCLES-1, go to WAIT; if fetch PC >= MEM_SIZE go to HALT instead.
REQ-018 WAIT: SHALL hold address stable, decrement counter; at counter 0 SHALL capture instr_in into instr, fetch PC into pc, assert instr_valid next cycle, go to HOLD.
REQ-019 HOLD: instr_valid high; on instr_valid && instr_ready SHALL advance fetch PC by 4 (modulo 2^32) and go to ISSUE; otherwise hold instr, pc, instr_valid unchanged.
REQ-020 Fetch latency from ISSUE to instr_valid SHALL be exactly RD_CYCLES+1 cycles; back-to-back throughput one word per RD_CYCLES+2 cycles with instr_ready high.
REQ-021 redirect_valid in any state other than HALT SHALL take priority over all other events: fetch PC <= redirect_addr, instr_valid <= 0 next cycle, any in-flight read discarded, state <= ISSUE.
REQ-022 redirect_valid coincident with an accepted handshake in HOLD: the accept SHALL complete (word consumed) and redirect target SHALL override the +4 increment.
REQ-023 redirect_valid in HALT SHALL restart fetch: halted <= 0, fetch PC <= redirect_addr, state <= ISSUE.
REQ-024 HALT: SHALL hold halted = 1, instr_valid = 0, address = last fetch PC.
REQ-025 address SHALL change only on the cycle entering ISSUE, never in WAIT.

Reset
REQ-026 When rst_n = 0 at a rising clk edge: state <= ISSUE, fetch PC <= RESET_PC, address <= RESET_PC, instr <= 0, pc <= 0, instr_valid <= 0, halted <= 0, err <= 0, counter <= 0.
REQ-027 Reset asserted mid-read or mid-HOLD SHALL discard the word; no instr_valid pulse after reset release until a fresh RD_CYCLES+1 latency elapses.

Configuration
REQ-028 Macro FETCH_ALIGN_CHECK_EN defined: redirect_addr[1:0] != 0 SHALL set err <= 1 (sticky until reset) and enter HALT with halted = 1; no fetch issued.
REQ-029 Macro FETCH_ALIGN_CHECK_EN undefined: redirect_addr[1:0] SHALL be forced to 2'b00, err SHALL be tied 0.

Verification
REQ-030 Reset release, RD_CYCLES=2, instr_ready=1, memory model returns word = address+0x100 -> instr 0x100/pc 0 valid at cycle 3, then 0x104/pc 4 at cycle 7, 0x108/pc 8 at cycle 11.
REQ-031 instr_ready=0 for 5 cycles while instr_valid -> instr, pc, address constant; raising instr_ready gives one accept and address advances by 4.
REQ-032 redirect_valid with redirect_addr=40 during WAIT at pc 12 -> in-flight word never valid; next valid word has pc 40.
REQ-033 Sequential fetch to address 52 with MEM_SIZE=52 -> halted=1 after pc 48 accepted, no further instr_valid; redirect to 8 -> halted=0, pc 8 valid after RD_CYCLES+1 cycles.
REQ-034 redirect_addr=0x0000_0022: with FETCH_ALIGN_CHECK_EN -> err=1, halted=1; without -> next fetch at 0x20, err=0.
REQ-035 rst_n=0 for one cycle during HOLD -> instr_valid=0 following cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word read, waits RD_CYCLES for memory, then holds the word
// until decode accepts it. Define FETCH_ALIGN_CHECK_EN to halt with a sticky err on misaligned redirects.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned MEM_SIZE  = 52
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] address,
    input  logic [31:0] instr_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        StIssue,
        StWait,
        StHold,
        StHalt
    } state_e;

    localparam logic [3:0] RdLoad = 4'(RD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        redir_bad;
    logic [31:0] redir_target;

    assign redir_target = redirect_addr & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q, err_d;

    assign redir_bad = redirect_valid && (redirect_addr[1:0] != 2'b00);
    assign err_d     = err_q | redir_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign redir_bad = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        unique case (state_q)
            StIssue: begin
                if (addr_q >= 32'(MEM_SIZE)) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else begin
                    state_d = StWait;
                    cnt_d   = RdLoad;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    instr_d = instr_in;
                    pc_d    = addr_q;
                    valid_d = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                if (valid_q && instr_ready) begin
                    valid_d = 1'b0;
                    addr_d  = addr_q + 32'd4;
                    state_d = StIssue;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
        endcase

        // Redirect overrides everything; an accept in the same cycle still consumes the word.
        if (redirect_valid) begin
            valid_d = 1'b0;
            if (redir_bad) begin
                state_d  = StHalt;
                halted_d = 1'b1;
            end else begin
                addr_d   = redir_target;
                state_d  = StIssue;
                halted_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIssue;
            addr_q   <= RESET_PC;
            cnt_q    <= 4'd0;
            instr_q  <= 32'd0;
            pc_q     <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign address     = addr_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule
